// File: rtl/wb_byte_loader_if.sv
// Byte-stream and Wishbone master signals of the byte loader, bundled so the
// loader and its environment (byte source plus RAM slave) connect through one port.
interface wb_byte_loader_if #(
    parameter int aw = 32
);
    logic [7:0]    i_byte_dat;
    logic          i_byte_vld;
    logic          o_byte_rdy;

    logic [aw-3:0] o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_cyc;
    logic          i_wb_ack;

    modport master (
        input  i_byte_dat, i_byte_vld, i_wb_ack,
        output o_byte_rdy, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
    );

    modport slave (
        output i_byte_dat, i_byte_vld, i_wb_ack,
        input  o_byte_rdy, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
    );
endinterface

// File: rtl/wb_byte_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes each word to
// consecutive Wishbone word addresses starting at a programmed base.
module wb_byte_loader #(
    parameter int aw = 32,
    parameter int lw = 16
) (
    input  logic          i_wb_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [aw-3:0] i_base_adr,
    input  logic [lw-1:0] i_len,
    output logic          o_busy,
    output logic          o_done,
    wb_byte_loader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    localparam logic [aw-3:0] ADR_ONE = {{(aw-3){1'b0}}, 1'b1};
    localparam logic [lw-1:0] LEN_ONE = {{(lw-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [aw-3:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [lw-1:0] rem_q, rem_d;
    logic [1:0]    lane_q, lane_d;

    // Every output is the registered copy of the next-value computed below, so
    // cyc/rdy/busy change on the same edge as the state transition causing them.
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        lane_d  = lane_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    adr_d  = i_base_adr;
                    rem_d  = i_len;
                    lane_d = '0;
                    dat_d  = '0;
                    sel_d  = '0;
                    if (i_len != '0) begin
                        state_d = COLLECT;
                        busy_d  = 1'b1;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            COLLECT: begin
                if (bus.i_byte_vld && rdy_q) begin
                    dat_d[{lane_q, 3'b000} +: 8] = bus.i_byte_dat;
                    sel_d[lane_q]                = 1'b1;
                    lane_d                       = lane_q + 2'd1;
                    rem_d                        = rem_q - LEN_ONE;
                    if (lane_q == 2'd3 || rem_q == LEN_ONE) begin
                        state_d = WRITE;
                        rdy_d   = 1'b0;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                    end
                end
            end

            // The slave toggles ack while cyc stays high, so cyc is dropped on
            // the acknowledged edge and only re-raised after another byte.
            WRITE: begin
                if (bus.i_wb_ack) begin
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    sel_d  = '0;
                    dat_d  = '0;
                    lane_d = '0;
                    adr_d  = adr_q + ADR_ONE;
                    if (rem_q != '0) begin
                        state_d = COLLECT;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end
                end
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_wb_adr   = adr_q;
    assign bus.o_wb_dat   = dat_q;
    assign bus.o_wb_sel   = sel_q;
    assign bus.o_wb_we    = we_q;
    assign bus.o_wb_cyc   = cyc_q;
    assign bus.o_byte_rdy = rdy_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_wb_byte_loader.sv
// Directed bench for wb_byte_loader: a small Wishbone RAM slave with adjustable
// ack delay records every acknowledged write for comparison with hand values.
module tb_wb_byte_loader;

    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-3:0] base_adr = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    wb_byte_loader_if #(.aw(AW)) bus ();

    wb_byte_loader #(.aw(AW), .lw(LW)) dut (
        .i_wb_clk   (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_base_adr (base_adr),
        .i_len      (len),
        .o_busy     (busy),
        .o_done     (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          ack_delay = 0;
    int          wait_cnt;
    int          wr_count = 0;
    logic [AW-3:0] wlog_adr [0:31];
    logic [31:0] wlog_dat [0:31];
    logic [3:0]  wlog_sel [0:31];
    logic [31:0] ram [0:63];
    logic        preset_req = 1'b0;
    logic [5:0]  preset_idx = '0;
    logic [31:0] preset_val = '0;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0] sel);
        merge_word = old_w;
        for (int k = 0; k < 4; k++)
            if (sel[k]) merge_word[8*k +: 8] = new_w[8*k +: 8];
    endfunction

    // RAM slave: acks ack_delay cycles after it first sees cyc, one-cycle ack pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_wb_ack <= 1'b0;
            wait_cnt     <= 0;
        end else begin
            if (preset_req) ram[preset_idx] <= preset_val;
            if (bus.o_wb_cyc && !bus.i_wb_ack) begin
                if (wait_cnt >= ack_delay) begin
                    bus.i_wb_ack <= 1'b1;
                    wait_cnt     <= 0;
                    if (bus.o_wb_we)
                        ram[bus.o_wb_adr[5:0]] <= merge_word(ram[bus.o_wb_adr[5:0]],
                                                             bus.o_wb_dat, bus.o_wb_sel);
                    wlog_adr[wr_count[4:0]] <= bus.o_wb_adr;
                    wlog_dat[wr_count[4:0]] <= bus.o_wb_dat;
                    wlog_sel[wr_count[4:0]] <= bus.o_wb_sel;
                    wr_count <= wr_count + 1;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                bus.i_wb_ack <= 1'b0;
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic apply_stimulus(input logic [AW-3:0] b, input logic [LW-1:0] l);
        base_adr = b;
        len      = l;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte with vld held high; returns at the negedge after acceptance.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.i_byte_dat = b;
        bus.i_byte_vld = 1'b1;
        while (bus.o_byte_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_output("byte_rdy_timeout", {63'd0, bus.o_byte_rdy}, 64'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen", {63'd0, done}, 64'd1);
        check_output("busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check_output("done_pulse_width", {63'd0, done}, 64'd0);
    endtask

    task automatic preset_ram(input logic [5:0] idx, input logic [31:0] val);
        preset_idx = idx;
        preset_val = val;
        preset_req = 1'b1;
        @(negedge clk);
        preset_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        bus.i_byte_dat = '0;
        bus.i_byte_vld = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_cyc",  {63'd0, bus.o_wb_cyc}, 64'd0);
        check_output("rst_we",   {63'd0, bus.o_wb_we}, 64'd0);
        check_output("rst_adr",  {34'd0, bus.o_wb_adr}, 64'd0);
        check_output("rst_dat",  {32'd0, bus.o_wb_dat}, 64'd0);
        check_output("rst_sel",  {60'd0, bus.o_wb_sel}, 64'd0);
        check_output("rst_rdy",  {63'd0, bus.o_byte_rdy}, 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] two full words, vld held high");
        s = wr_count;
        apply_stimulus(30'h10, 16'd8);
        check_output("t1_busy", {63'd0, busy}, 64'd1);
        check_output("t1_rdy",  {63'd0, bus.o_byte_rdy}, 64'd1);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        check_output("t1_cyc_n",  {63'd0, bus.o_wb_cyc}, 64'd1);
        check_output("t1_we_n",   {63'd0, bus.o_wb_we}, 64'd1);
        check_output("t1_rdy_n",  {63'd0, bus.o_byte_rdy}, 64'd0);
        check_output("t1_adr_n",  {34'd0, bus.o_wb_adr}, 64'h10);
        check_output("t1_dat_n",  {32'd0, bus.o_wb_dat}, 64'h44332211);
        check_output("t1_sel_n",  {60'd0, bus.o_wb_sel}, 64'hF);
        @(negedge clk);
        check_output("t1_ack_n1", {63'd0, bus.i_wb_ack}, 64'd1);
        check_output("t1_cyc_n1", {63'd0, bus.o_wb_cyc}, 64'd1);
        @(negedge clk);
        check_output("t1_cyc_n2", {63'd0, bus.o_wb_cyc}, 64'd0);
        check_output("t1_rdy_n2", {63'd0, bus.o_byte_rdy}, 64'd1);
        check_output("t1_sel_n2", {60'd0, bus.o_wb_sel}, 64'd0);
        check_output("t1_dat_n2", {32'd0, bus.o_wb_dat}, 64'd0);
        check_output("t1_adr_n2", {34'd0, bus.o_wb_adr}, 64'h11);
        push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
        bus.i_byte_vld = 1'b0;
        wait_done(20);
        check_output("t1_writes", 64'(wr_count - s), 64'd2);
        check_output("t1_w0_adr", {34'd0, wlog_adr[s]}, 64'h10);
        check_output("t1_w0_dat", {32'd0, wlog_dat[s]}, 64'h44332211);
        check_output("t1_w1_adr", {34'd0, wlog_adr[s+1]}, 64'h11);
        check_output("t1_w1_dat", {32'd0, wlog_dat[s+1]}, 64'h88776655);
        check_output("t1_w1_sel", {60'd0, wlog_sel[s+1]}, 64'hF);
        check_output("t1_ram10",  {32'd0, ram[6'h10]}, 64'h44332211);
        check_output("t1_ram11",  {32'd0, ram[6'h11]}, 64'h88776655);

        $display("[TB] partial final word");
        preset_ram(6'h21, 32'h12345678);
        s = wr_count;
        apply_stimulus(30'h20, 16'd5);
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
        push_byte(8'hEE);
        bus.i_byte_vld = 1'b0;
        check_output("t2_cyc",  {63'd0, bus.o_wb_cyc}, 64'd1);
        check_output("t2_adr",  {34'd0, bus.o_wb_adr}, 64'h21);
        check_output("t2_dat",  {32'd0, bus.o_wb_dat}, 64'h000000EE);
        check_output("t2_sel",  {60'd0, bus.o_wb_sel}, 64'h1);
        wait_done(20);
        check_output("t2_writes", 64'(wr_count - s), 64'd2);
        check_output("t2_w1_sel", {60'd0, wlog_sel[s+1]}, 64'h1);
        check_output("t2_ram20",  {32'd0, ram[6'h20]}, 64'hDDCCBBAA);
        check_output("t2_ram21",  {32'd0, ram[6'h21]}, 64'h123456EE);

        $display("[TB] zero length");
        s = wr_count;
        base_adr = 30'h7;
        len      = 16'd0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_output("t3_done_c1", {63'd0, done}, 64'd0);
        check_output("t3_busy_c1", {63'd0, busy}, 64'd0);
        check_output("t3_cyc_c1",  {63'd0, bus.o_wb_cyc}, 64'd0);
        @(negedge clk);
        check_output("t3_done_c2", {63'd0, done}, 64'd1);
        check_output("t3_busy_c2", {63'd0, busy}, 64'd0);
        check_output("t3_cyc_c2",  {63'd0, bus.o_wb_cyc}, 64'd0);
        @(negedge clk);
        check_output("t3_done_c3", {63'd0, done}, 64'd0);
        check_output("t3_writes",  64'(wr_count - s), 64'd0);

        $display("[TB] delayed ack");
        ack_delay = 5;
        s = wr_count;
        apply_stimulus(30'h08, 16'd6);
        push_byte(8'h01); push_byte(8'h23); push_byte(8'h45); push_byte(8'h67);
        bus.i_byte_dat = 8'h89;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check_output("t4_cyc", {63'd0, bus.o_wb_cyc}, 64'd1);
            check_output("t4_adr", {34'd0, bus.o_wb_adr}, 64'h08);
            check_output("t4_dat", {32'd0, bus.o_wb_dat}, 64'h67452301);
            check_output("t4_sel", {60'd0, bus.o_wb_sel}, 64'hF);
            check_output("t4_rdy", {63'd0, bus.o_byte_rdy}, 64'd0);
        end
        push_byte(8'h89); push_byte(8'hAB);
        bus.i_byte_vld = 1'b0;
        wait_done(60);
        ack_delay = 0;
        check_output("t4_writes", 64'(wr_count - s), 64'd2);
        check_output("t4_w0_dat", {32'd0, wlog_dat[s]}, 64'h67452301);
        check_output("t4_w1_adr", {34'd0, wlog_adr[s+1]}, 64'h09);
        check_output("t4_w1_dat", {32'd0, wlog_dat[s+1]}, 64'h0000AB89);
        check_output("t4_w1_sel", {60'd0, wlog_sel[s+1]}, 64'h3);

        $display("[TB] reset during bus cycle");
        ack_delay = 10;
        s = wr_count;
        apply_stimulus(30'h30, 16'd4);
        push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
        bus.i_byte_vld = 1'b0;
        check_output("t5_cyc_pre", {63'd0, bus.o_wb_cyc}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("t5_cyc",  {63'd0, bus.o_wb_cyc}, 64'd0);
        check_output("t5_we",   {63'd0, bus.o_wb_we}, 64'd0);
        check_output("t5_adr",  {34'd0, bus.o_wb_adr}, 64'd0);
        check_output("t5_dat",  {32'd0, bus.o_wb_dat}, 64'd0);
        check_output("t5_sel",  {60'd0, bus.o_wb_sel}, 64'd0);
        check_output("t5_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        apply_stimulus(30'h31, 16'd4);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
        bus.i_byte_vld = 1'b0;
        wait_done(20);
        check_output("t5_writes", 64'(wr_count - s), 64'd1);
        check_output("t5_w0_adr", {34'd0, wlog_adr[s]}, 64'h31);
        check_output("t5_w0_dat", {32'd0, wlog_dat[s]}, 64'h04030201);

        $display("[TB] address wrap and ignored restart");
        s = wr_count;
        apply_stimulus(30'h3FFFFFFF, 16'd8);
        push_byte(8'h01); push_byte(8'h02);
        base_adr = 30'h5;
        len      = 16'd1;
        start    = 1'b1;
        push_byte(8'h03);
        start = 1'b0;
        push_byte(8'h04); push_byte(8'h05); push_byte(8'h06); push_byte(8'h07);
        push_byte(8'h08);
        bus.i_byte_vld = 1'b0;
        wait_done(30);
        check_output("t6_w0_adr", {34'd0, wlog_adr[s]}, 64'h3FFFFFFF);
        check_output("t6_w0_dat", {32'd0, wlog_dat[s]}, 64'h04030201);
        check_output("t6_w1_adr", {34'd0, wlog_adr[s+1]}, 64'h0);
        check_output("t6_w1_dat", {32'd0, wlog_dat[s+1]}, 64'h08070605);
        check_output("t6_ram63",  {32'd0, ram[6'h3F]}, 64'h04030201);
        check_output("t6_ram0",   {32'd0, ram[6'h00]}, 64'h08070605);
        repeat (5) @(negedge clk);
        check_output("t6_writes", 64'(wr_count - s), 64'd2);
        check_output("t6_busy",   {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_byte_loader.md
Name: wb_byte_loader

Overview:
Wishbone write initiator that drives the single-port word RAM slave from the master side. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. It then issues one Wishbone single write per word to consecutive word addresses, starting at a programmed base. It is used to load program or data images (e.g. from a UART byte stream) into on-chip RAM at run time, as an alternative to preloading at elaboration.

Parameters:
aw, 32, byte address width; the bus carries word address bits aw-1:2
lw, 16, width of the byte-length field

Ports:
i_wb_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start request; sampled only in IDLE
i_base_adr  in  aw-2  word address of the first write, bits aw-1:2
i_len  in  lw  number of bytes to load; 0 is legal
i_byte_dat  in  8  stream byte
i_byte_vld  in  1  stream byte valid
o_byte_rdy  out  1  loader can accept a byte
o_busy  out  1  a transfer is in progress
o_done  out  1  one-cycle pulse when the transfer is complete
o_wb_adr  out  aw-2  Wishbone word address
o_wb_dat  out  32  Wishbone write data
o_wb_sel  out  4  Wishbone byte lane selects
o_wb_we  out  1  Wishbone write enable
o_wb_cyc  out  1  Wishbone cycle/strobe
i_wb_ack  in  1  Wishbone acknowledge from the slave

Behaviour:
- Reset (asynchronous, i_rst_n=0): all outputs are 0, FSM goes to IDLE, and counters and the pack register are cleared. Reset asserted mid-transfer drops o_wb_cyc immediately, and the partial word is discarded.
- FSM states: IDLE, COLLECT, WRITE, DONE. All outputs are registered.
- IDLE:
  - i_start=1 latches i_base_adr into the address register and i_len into the remaining-byte counter; lane index = 0.
  - If i_len != 0, go to COLLECT and set o_busy=1 from the next cycle.
  - If i_len == 0, go to DONE with no bus cycle.
- COLLECT:
  - o_byte_rdy=1. A byte is accepted when i_byte_vld & o_byte_rdy.
  - Byte k of a word goes to o_wb_dat[8k+7:8k], and sel bit k is set.
  - Each accepted byte decrements the remaining-byte counter and increments the lane index.
  - When lane 3 is filled, or the remaining count reaches 0, go to WRITE.
- WRITE:
  - o_byte_rdy=0. o_wb_cyc=o_wb_we=1 from the cycle after the transition.
  - adr, dat and sel are held stable until the ack.
  - On the edge where i_wb_ack=1: deassert cyc and we; clear sel, dat and lane index; increment the address modulo 2^(aw-2).
  - Then go to COLLECT if bytes remain, otherwise to DONE.
  - Waits indefinitely for ack; there is no timeout.
- Unused lanes in a final partial word have sel=0 and dat byte=0.
- DONE: o_done=1 for exactly one cycle and o_busy=0; return to IDLE.
- o_busy is 1 in COLLECT and WRITE only. i_start is ignored in any state other than IDLE.
- Throughput against a slave that acks one cycle after cyc:
  - Last byte of a word accepted at edge N.
  - cyc high after N, ack seen at N+1, cyc low after N+2.
  - o_byte_rdy high again after N+2.
  - So a full word costs 4 byte cycles + 2.
- cyc is always low for at least one cycle between consecutive writes. This is required because the slave's ack toggles while cyc is held.
- i_byte_vld in IDLE, WRITE or DONE is not accepted, and no data is consumed.

Test Plan:
- base=0x10, len=8, bytes 11..88 with vld held high:
  - write adr=0x10 dat=0x44332211 sel=F, then adr=0x11 dat=0x88776655 sel=F
  - exactly 2 ack'd cycles, o_done pulse of 1 cycle, readback from the RAM model matches
- len=5, bytes AA BB CC DD EE:
  - second write adr=base+1 dat=0x000000EE sel=0001
  - RAM bytes 1-3 of that word are unchanged
- len=0 with start:
  - o_done pulses 2 cycles after start, o_busy never rises, o_wb_cyc never rises
- Slave delays ack by 5 cycles:
  - cyc, adr, dat and sel stay stable for all 5 cycles, o_byte_rdy=0 throughout, no bytes are lost
- Reset asserted while cyc=1 mid-transfer:
  - o_wb_cyc=0 asynchronously, all outputs 0
  - a new transfer after reset writes correct data from its own base
- i_start pulsed while busy, and a base near the top of the address space:
  - the second start is ignored
  - the address wraps from 2^(aw-2)-1 to 0
